// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the datapath (master) and pipe_hazard_ctrl (slave).
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;
  logic        ex_branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_en;
  logic        if_de_en;
  logic        de_ex_en;
  logic        ex_mem_en;
  logic        mem_wb_en;
  logic        if_de_flush;
  logic        de_ex_flush;
  logic        mem_wb_flush;
  logic        mem_err;
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_count;

  modport master (
    output id_rs1, id_rs2, ex_rd, ex_mem_read, ex_branch_taken, mem_req, mem_ready,
    input  pc_en, if_de_en, de_ex_en, ex_mem_en, mem_wb_en,
    input  if_de_flush, de_ex_flush, mem_wb_flush, mem_err,
    input  perf_stall_cycles, perf_flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, ex_rd, ex_mem_read, ex_branch_taken, mem_req, mem_ready,
    output pc_en, if_de_en, de_ex_en, ex_mem_en, mem_wb_en,
    output if_de_flush, de_ex_flush, mem_wb_flush, mem_err,
    output perf_stall_cycles, perf_flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, taken branch, data-memory wait.
// Perf counters are built only when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {StRun, StMemWait, StTrap} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;

  logic pc_en_c, if_de_en_c, de_ex_en_c, ex_mem_en_c, mem_wb_en_c;
  logic if_de_flush_c, de_ex_flush_c, mem_wb_flush_c;
  logic flush_evt;
  logic run_eval;
  logic load_use;

  assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                    ((hz.ex_rd == hz.id_rs1) || (hz.ex_rd == hz.id_rs2));

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    mem_err_d      = mem_err_q;
    pc_en_c        = 1'b1;
    if_de_en_c     = 1'b1;
    de_ex_en_c     = 1'b1;
    ex_mem_en_c    = 1'b1;
    mem_wb_en_c    = 1'b1;
    if_de_flush_c  = 1'b0;
    de_ex_flush_c  = 1'b0;
    mem_wb_flush_c = 1'b0;
    flush_evt      = 1'b0;
    run_eval       = 1'b0;

    unique case (state_q)
      StRun: begin
        if (hz.mem_req && !hz.mem_ready) begin
          state_d    = StMemWait;
          wait_cnt_d = CntW'(1);
        end else begin
          run_eval = 1'b1;
        end
      end
      StMemWait: begin
        if (!hz.mem_ready) begin
          if (wait_cnt_q == CntW'(MEM_TIMEOUT)) begin
            state_d   = StTrap;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + CntW'(1);
          end
        end else begin
          // Completion: the frozen EX hazards get evaluated in this same cycle.
          run_eval   = 1'b1;
          state_d    = StRun;
          wait_cnt_d = '0;
        end
      end
      StTrap: begin
        state_d = StTrap;
      end
      default: begin
        state_d    = StRun;
        wait_cnt_d = '0;
      end
    endcase

    if (run_eval) begin
      if (hz.ex_branch_taken) begin
        if_de_flush_c = 1'b1;
        de_ex_flush_c = 1'b1;
        flush_evt     = 1'b1;
      end else if (load_use) begin
        pc_en_c       = 1'b0;
        if_de_en_c    = 1'b0;
        de_ex_flush_c = 1'b1;
      end
    end else begin
      pc_en_c        = 1'b0;
      if_de_en_c     = 1'b0;
      de_ex_en_c     = 1'b0;
      ex_mem_en_c    = 1'b0;
      mem_wb_en_c    = 1'b0;
      // Bubble into WB so a held MEM result is not written back twice.
      mem_wb_flush_c = (state_q != StTrap);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign hz.pc_en        = rst & pc_en_c;
  assign hz.if_de_en     = rst & if_de_en_c;
  assign hz.de_ex_en     = rst & de_ex_en_c;
  assign hz.ex_mem_en    = rst & ex_mem_en_c;
  assign hz.mem_wb_en    = rst & mem_wb_en_c;
  assign hz.if_de_flush  = rst & if_de_flush_c;
  assign hz.de_ex_flush  = rst & de_ex_flush_c;
  assign hz.mem_wb_flush = rst & mem_wb_flush_c;
  assign hz.mem_err      = mem_err_q;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Both counters saturate instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en_c && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (flush_evt && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.perf_stall_cycles = stall_cnt_q;
  assign hz.perf_flush_count  = flush_cnt_q;
`else
  logic unused_flush_evt;
  assign unused_flush_evt     = flush_evt;
  assign hz.perf_stall_cycles = 32'd0;
  assign hz.perf_flush_count  = 32'd0;
`endif
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard and stall controller for the segmented 5-stage core. It generates the enable and flush controls for the PC and the four inter-stage registers (IF/DE, DE/EX, EX/MEM, MEM/WB). It handles load-use stalls, taken-branch flushes and multi-cycle data-memory waits, including a wait timeout. It sits beside the datapath, and every pipeline register's `enable` input is driven from here.

## Interface
- `MEM_TIMEOUT`, default 255: maximum consecutive MEM_WAIT cycles before the error trap (1..65535).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in DE.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_mem_read`  in  1  instruction in EX is a load.
- `ex_branch_taken`  in  1  branch or jump in EX resolved taken.
- `mem_req`  in  1  instruction in MEM accesses data memory.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `pc_en`, `if_de_en`, `de_ex_en`, `ex_mem_en`, `mem_wb_en`  out  1 each  register enables.
- `if_de_flush`, `de_ex_flush`, `mem_wb_flush`  out  1 each  load a bubble (NOP, all-zero) instead of data.
- `mem_err`  out  1  sticky memory-timeout error.
- `perf_stall_cycles`  out  32  cycles with `pc_en`=0.
- `perf_flush_count`  out  32  taken-branch flushes.

## Operation
- FSM states:
  - RUN: default.
  - MEM_WAIT: data memory outstanding.
  - TRAP: timeout, terminal until reset.
- Outputs are combinational from the current state and inputs. Only the state, the wait counter, `mem_err` and the perf counters are registered.
- RUN, default outputs: all enables 1, all flushes 0.
- RUN, priority 1 (memory wait): `mem_req`=1 and `mem_ready`=0.
  - All enables 0; `mem_wb_flush`=1 so WB does not repeat the write.
  - Next state MEM_WAIT; wait counter is 1.
- RUN, priority 2 (taken branch): `ex_branch_taken`=1.
  - `if_de_flush`=1 and `de_ex_flush`=1; all enables stay 1, so the PC loads the target.
  - `perf_flush_count` increments.
- RUN, priority 3 (load-use): `ex_mem_read`=1, `ex_rd`≠0, and `ex_rd`==`id_rs1` or `ex_rd`==`id_rs2`.
  - `pc_en`=0, `if_de_en`=0, `de_ex_flush`=1; the other enables are 1.
  - Exactly one bubble is inserted. Next cycle the load is in MEM and the condition clears naturally.
- A branch and a load-use in the same cycle resolve as branch only, because the stalled instruction is being flushed anyway.
- MEM_WAIT:
  - While `mem_ready`=0: outputs are identical to the RUN memory-wait case and the wait counter increments.
  - On `mem_ready`=1: outputs revert to RUN evaluation in that same cycle, the MEM/WB register captures the result, and next state is RUN.
  - Branch and load-use conditions held in the frozen EX are evaluated on the exit cycle.
- Timeout: in MEM_WAIT with `mem_ready`=0 and the wait counter == `MEM_TIMEOUT`, next state is TRAP and `mem_err` sets.
  - `mem_ready` arriving in the same cycle as the limit wins, and no error is raised.
- TRAP: all enables 0, all flushes 0, `mem_err`=1. The block stays in TRAP until reset.
- Wait counter width is ceil(log2(MEM_TIMEOUT+1)). It clears on entry to RUN.

## Timing
- Reset (`rst`=0), effective immediately and asynchronously:
  - State RUN, wait counter 0, `mem_err`=0, perf counters 0.
  - While `rst`=0, all enables and flushes are forced to 0.
- Control latency is 0 cycles: a hazard visible on inputs in cycle N gates the register edge at the end of cycle N.
- A load-use costs 1 stall cycle. A taken branch costs 2 flushed slots. A memory wait costs the number of cycles with `mem_ready`=0.
- Reset asserted mid-MEM_WAIT or in TRAP returns to RUN with no residual counter or error state.
- Counters saturate at 0xFFFF_FFFF; they do not wrap.

## Configuration
- `PIPE_HAZARD_PERF_EN` defined: `perf_stall_cycles` and `perf_flush_count` are implemented as described.
- Not defined: no counter registers are built, and both ports are tied to 0. All other behaviour is unchanged.

## Test plan
- Load-use stall:
  - Stimulus: `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5.
  - Response: one cycle with `pc_en`=0, `if_de_en`=0, `de_ex_flush`=1; `perf_stall_cycles`=1.
  - Same stimulus with `ex_rd`=0 produces no stall.
- Branch flush:
  - Stimulus: `ex_branch_taken`=1 together with a load-use match.
  - Response: `if_de_flush`=`de_ex_flush`=1, `pc_en`=1, `perf_flush_count`=1.
- Memory wait:
  - Stimulus: `mem_req`=1 with `mem_ready` low for 3 cycles, then high.
  - Response: 3 cycles with all enables 0 and `mem_wb_flush`=1; enables are 1 on the 4th cycle; `perf_stall_cycles`=3.
- Timeout:
  - Stimulus: `MEM_TIMEOUT`=4, `mem_ready` held low.
  - Response: `mem_err`=1 after the 4th wait cycle, and the block stays in TRAP.
  - Repeat with `mem_ready`=1 exactly at the limit: `mem_err` stays 0.
- Reset mid-operation:
  - Stimulus: drop `rst` during MEM_WAIT.
  - Response: outputs are 0 immediately; after release, the block is in RUN with all enables 1 and counters 0.
- Build without `PIPE_HAZARD_PERF_EN`: both perf ports read 0 throughout the stall scenarios.
